toggle_stream_decoder: RTL

TOGGLE_STREAM_DECODER -- requirements
Module: toggle_stream_decoder

---
 rtl/toggle_stream_decoder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/toggle_stream_decoder.sv
// Rebuilds a level waveform from a stream of toggle bits and packs the decoded
// levels into WIDTH-bit words. Words go out over a valid/ready port backed by one pending slot.
module toggle_stream_decoder #(
    parameter int   WIDTH      = 8,
    parameter logic INIT_LEVEL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             t_valid,
    input  logic             t_bit,
    output logic             t_ready,
    output logic [WIDTH-1:0] d_data,
    output logic             d_valid,
    input  logic             d_ready,
    output logic             level,
    output logic [15:0]      toggle_cnt
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        COLLECT = 1'b0,
        STALL   = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] d_data_q, d_data_d;
    logic             d_valid_q, d_valid_d;
    logic             level_q, level_d;
    logic [15:0]      toggle_cnt_q, toggle_cnt_d;

    logic             t_beat;
    logic             d_beat;
    logic             new_bit;
    logic [WIDTH-1:0] word_w;

    assign t_ready    = (state_q == COLLECT);
    assign t_beat     = t_valid && t_ready;
    assign d_beat     = d_valid_q && d_ready;
    assign new_bit    = level_q ^ t_bit;

    assign d_data     = d_data_q;
    assign d_valid    = d_valid_q;
    assign level      = level_q;
    assign toggle_cnt = toggle_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= COLLECT;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            pend_q       <= '0;
            d_data_q     <= '0;
            d_valid_q    <= 1'b0;
            level_q      <= INIT_LEVEL;
            toggle_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            pend_q       <= pend_d;
            d_data_q     <= d_data_d;
            d_valid_q    <= d_valid_d;
            level_q      <= level_d;
            toggle_cnt_q <= toggle_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        pend_d       = pend_q;
        d_data_d     = d_data_q;
        d_valid_d    = d_valid_q;
        level_d      = level_q;
        toggle_cnt_d = toggle_cnt_q;

        word_w            = shift_q;
        word_w[bit_cnt_q] = new_bit;

        // A consumed word drops valid unless a replacement is loaded below.
        if (d_beat) begin
            d_valid_d = 1'b0;
        end

        if (flush) begin
            state_d   = COLLECT;
            bit_cnt_d = '0;
            shift_d   = '0;
            pend_d    = '0;
            level_d   = INIT_LEVEL;
        end else if (state_q == STALL) begin
            if (d_beat) begin
                d_data_d  = pend_q;
                d_valid_d = 1'b1;
                pend_d    = '0;
                state_d   = COLLECT;
            end
        end else if (t_beat) begin
            level_d = new_bit;
            if (t_bit && (toggle_cnt_q != 16'hFFFF)) begin
                toggle_cnt_d = toggle_cnt_q + 16'd1;
            end
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                shift_d   = '0;
                // Output slot busy and not draining this cycle: park the word.
                if (!d_valid_q || d_ready) begin
                    d_data_d  = word_w;
                    d_valid_d = 1'b1;
                end else begin
                    pend_d  = word_w;
                    state_d = STALL;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
                shift_d   = word_w;
            end
        end
    end

endmodule
